// File: rtl/apb_pkg.sv
// Shared APB constants: default widths, wait-state timeout and FSM state encodings.
// Used by the requester, the GPIO slave and the benches.
package apb_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned TIMEOUT_DEF = 16;

  typedef logic [1:0] apb_state_t;

  localparam apb_state_t IDLE   = 2'd0;
  localparam apb_state_t SETUP  = 2'd1;
  localparam apb_state_t ACCESS = 2'd2;

  // Width of a counter that must hold 0..limit; at least one bit so a disabled timer still elaborates.
  function automatic int cnt_width(int unsigned limit);
    return (limit == 0) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the APB requester: cleared when a transfer enters SETUP,
// counts ACCESS cycles with PREADY low, saturates at TIMEOUT and flags the last
// allowed wait cycle so the FSM can abort on that edge.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  input  logic inc,
  output logic expire
);

  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

  logic [CW-1:0] cnt;

  // Clear has priority; increments stop at LIMIT so the counter never wraps.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // This wait cycle is the TIMEOUT-th one; TIMEOUT of zero never expires.
  assign expire = (TIMEOUT != 0) && inc && (cnt == LIMIT - CW'(1));

endmodule

// File: rtl/apb_master.sv
// Single-outstanding APB requester: accepts one valid/ready command, runs it as an
// APB SETUP/ACCESS transfer and returns exactly one response pulse, or an error
// response if the peripheral holds PREADY low for TIMEOUT ACCESS cycles.
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  apb_state_t        state;
  apb_state_t        state_next;
  logic              rsp_valid_next;
  logic              rsp_err_next;
  logic [DATA_W-1:0] rsp_rdata_next;
  logic              accept;
  logic              expire;

  assign accept    = (state == IDLE) && cmd_valid;
  // Decoded straight from state so a reset drops the bus controls without waiting for a clock.
  assign cmd_ready = (state == IDLE);
  assign PSEL      = (state != IDLE);
  assign PENABLE   = (state == ACCESS);

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (accept),
    .inc     ((state == ACCESS) && !PREADY),
    .expire  (expire)
  );

  // Next state and response; PREADY is checked before the timeout so a late completion still counts.
  always_comb begin
    state_next     = state;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) state_next = SETUP;
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (PREADY) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = PWRITE ? '0 : PRDATA;
        end else if (expire) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and registered response pulse.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  // Command payload is captured only on accept, so it stays stable through the transfer
  // and holds its last value while idle.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master. Instance a uses TIMEOUT=4, instance b uses
// TIMEOUT=2; they share the command payload and the APB slave-side inputs.
module tb_apb_master;

  typedef struct packed {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  logic       PCLK = 1'b0;
  logic       PRESETn;
  logic       cmd_write;
  logic [7:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic [7:0] PRDATA;
  logic       PREADY;

  logic       cmd_valid_a, cmd_ready_a, rsp_valid_a, rsp_err_a;
  logic       psel_a, penable_a, pwrite_a;
  logic [7:0] rsp_rdata_a, paddr_a, pwdata_a;

  logic       cmd_valid_b, cmd_ready_b, rsp_valid_b, rsp_err_b;
  logic       psel_b, penable_b, pwrite_b;
  logic [7:0] rsp_rdata_b, paddr_b, pwdata_b;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  always #5 PCLK = ~PCLK;

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(4)) u_dut_a (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a),
    .PSEL(psel_a), .PENABLE(penable_a), .PWRITE(pwrite_a), .PADDR(paddr_a),
    .PWDATA(pwdata_a), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  apb_master #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(2)) u_dut_b (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b),
    .PSEL(psel_b), .PENABLE(penable_b), .PWRITE(pwrite_b), .PADDR(paddr_b),
    .PWDATA(pwdata_b), .PRDATA(PRDATA), .PREADY(PREADY)
  );

  task automatic test_reset();
    PRESETn = 1'b1;
    cmd_valid_a = 1'b0; cmd_valid_b = 1'b0;
    cmd_write = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    PRDATA = 8'h00; PREADY = 1'b0;
    #2 PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (cmd_ready_a !== 1'b1) begin
      errors++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready_a);
    end
    checks++;
    if ({psel_a, penable_a, pwrite_a} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {psel_a, penable_a, pwrite_a});
    end
    checks++;
    if ({paddr_a, pwdata_a} !== 16'h0000) begin
      errors++; $display("FAIL reset_payload: got %h want 0000", {paddr_a, pwdata_a});
    end
    checks++;
    if ({rsp_valid_a, rsp_err_a, rsp_rdata_a} !== 10'h000) begin
      errors++; $display("FAIL reset_rsp: got %h want 000", {rsp_valid_a, rsp_err_a, rsp_rdata_a});
    end
    checks++;
    if ({cmd_ready_b, psel_b, penable_b} !== 3'b100) begin
      errors++; $display("FAIL reset_b: got %b want 100", {cmd_ready_b, psel_b, penable_b});
    end
    @(posedge PCLK); #1 PRESETn = 1'b1;
  endtask

  task automatic test_write();
    int   n;
    bit   got;
    rsp_t e;
    PREADY = 1'b1; PRDATA = 8'h5A;
    cmd_write = 1'b1; cmd_addr = 8'hFF; cmd_wdata = 8'hCC;
    @(negedge PCLK);
    checks++;
    if (cmd_ready_a !== 1'b1) begin
      errors++; $display("FAIL write_idle_ready: got %b want 1", cmd_ready_a);
    end
    cmd_valid_a = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 8'h00});
    @(posedge PCLK); #1;
    cmd_valid_a = 1'b0; cmd_addr = 8'h00; cmd_wdata = 8'h00;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge PCLK); n++;
      if (n == 1) begin
        checks++;
        if ({psel_a, penable_a, cmd_ready_a} !== 3'b100) begin
          errors++; $display("FAIL write_setup: got %b want 100", {psel_a, penable_a, cmd_ready_a});
        end
      end
      if (n == 2) begin
        checks++;
        if ({psel_a, penable_a, pwrite_a, paddr_a, pwdata_a} !== {3'b111, 8'hFF, 8'hCC}) begin
          errors++;
          $display("FAIL write_access: got %h want %h",
                   {psel_a, penable_a, pwrite_a, paddr_a, pwdata_a}, {3'b111, 8'hFF, 8'hCC});
        end
      end
      if (rsp_valid_a === 1'b1) begin
        got = 1'b1;
        checks++;
        if (n != 3) begin
          errors++; $display("FAIL write_latency: got %0d want 3", n);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL write_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err_a, rsp_rdata_a} !== e) begin
            errors++; $display("FAIL write_rsp: got %h want %h", {rsp_err_a, rsp_rdata_a}, e);
          end
        end
      end
    end
    if (!got) begin
      checks++; errors++; exp_q.delete();
      $display("FAIL write_timeout: got no rsp_valid want one within 20 cycles");
    end
  endtask

  task automatic test_read_wait();
    int   n;
    int   pen_cnt;
    bit   got;
    rsp_t e;
    PREADY = 1'b0; PRDATA = 8'h5A;
    cmd_write = 1'b0; cmd_addr = 8'h10; cmd_wdata = 8'h00;
    cmd_valid_a = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 8'hA5});
    @(posedge PCLK); #1;
    cmd_valid_a = 1'b0; cmd_addr = 8'hEE;
    n = 0; pen_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge PCLK); n++;
      if (psel_a === 1'b1) begin
        checks++;
        if (paddr_a !== 8'h10) begin
          errors++; $display("FAIL read_addr_stable: got %h want 10", paddr_a);
        end
      end
      if (penable_a === 1'b1) pen_cnt++;
      if (n == 4) begin
        PREADY = 1'b1; PRDATA = 8'hA5;
      end
      if (rsp_valid_a === 1'b1) begin
        got = 1'b1;
        checks++;
        if (n != 5) begin
          errors++; $display("FAIL read_latency: got %0d want 5", n);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL read_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err_a, rsp_rdata_a} !== e) begin
            errors++; $display("FAIL read_rsp: got %h want %h", {rsp_err_a, rsp_rdata_a}, e);
          end
        end
      end
    end
    if (!got) begin
      checks++; errors++; exp_q.delete();
      $display("FAIL read_timeout: got no rsp_valid want one within 20 cycles");
    end
    checks++;
    if (pen_cnt != 3) begin
      errors++; $display("FAIL read_penable_cycles: got %0d want 3", pen_cnt);
    end
  endtask

  task automatic test_timeout();
    int   n;
    int   pen_cnt;
    bit   got;
    rsp_t e;
    PREADY = 1'b0; PRDATA = 8'h77;
    cmd_write = 1'b0; cmd_addr = 8'h33;
    cmd_valid_a = 1'b1;
    exp_q.push_back('{err: 1'b1, rdata: 8'h00});
    @(posedge PCLK); #1 cmd_valid_a = 1'b0;
    n = 0; pen_cnt = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge PCLK); n++;
      if (penable_a === 1'b1) pen_cnt++;
      if (rsp_valid_a === 1'b1) begin
        got = 1'b1;
        checks++;
        if (n != 6) begin
          errors++; $display("FAIL timeout_latency: got %0d want 6", n);
        end
        checks++;
        if ({psel_a, cmd_ready_a} !== 2'b01) begin
          errors++; $display("FAIL timeout_psel: got %b want 01", {psel_a, cmd_ready_a});
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL timeout_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err_a, rsp_rdata_a} !== e) begin
            errors++; $display("FAIL timeout_rsp: got %h want %h", {rsp_err_a, rsp_rdata_a}, e);
          end
        end
      end
    end
    if (!got) begin
      checks++; errors++; exp_q.delete();
      $display("FAIL timeout_wait: got no rsp_valid want one within 20 cycles");
    end
    checks++;
    if (pen_cnt != 4) begin
      errors++; $display("FAIL timeout_access_cycles: got %0d want 4", pen_cnt);
    end
    // Follow-up read must complete normally.
    PREADY = 1'b1; PRDATA = 8'h3C; cmd_addr = 8'h22;
    cmd_valid_a = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 8'h3C});
    @(posedge PCLK); #1 cmd_valid_a = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge PCLK); n++;
      if (rsp_valid_a === 1'b1) begin
        got = 1'b1;
        checks++;
        if (n != 3) begin
          errors++; $display("FAIL after_timeout_latency: got %0d want 3", n);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL after_timeout_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err_a, rsp_rdata_a} !== e) begin
            errors++;
            $display("FAIL after_timeout_rsp: got %h want %h", {rsp_err_a, rsp_rdata_a}, e);
          end
        end
      end
    end
    if (!got) begin
      checks++; errors++; exp_q.delete();
      $display("FAIL after_timeout_wait: got no rsp_valid want one within 20 cycles");
    end
  endtask

  task automatic test_back_to_back();
    int   n;
    int   seen;
    rsp_t e;
    PREADY = 1'b1; PRDATA = 8'h99;
    cmd_write = 1'b1; cmd_addr = 8'h40; cmd_wdata = 8'h11;
    cmd_valid_a = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 8'h00});
    @(posedge PCLK); #1;
    // Second command presented while busy; it must wait for the IDLE cycle.
    cmd_write = 1'b0; cmd_addr = 8'h41; cmd_wdata = 8'hEE;
    exp_q.push_back('{err: 1'b0, rdata: 8'h99});
    n = 0; seen = 0;
    while (seen < 2 && n < 20) begin
      @(negedge PCLK); n++;
      if (n == 1 || n == 2) begin
        checks++;
        if ({cmd_ready_a, pwrite_a, paddr_a} !== {2'b01, 8'h40}) begin
          errors++;
          $display("FAIL b2b_busy: got %h want %h", {cmd_ready_a, pwrite_a, paddr_a}, {2'b01, 8'h40});
        end
      end
      if (n == 3) begin
        checks++;
        if ({psel_a, cmd_ready_a} !== 2'b01) begin
          errors++; $display("FAIL b2b_idle_cycle: got %b want 01", {psel_a, cmd_ready_a});
        end
      end
      if (n == 4) begin
        checks++;
        if ({psel_a, penable_a, pwrite_a, paddr_a} !== {3'b100, 8'h41}) begin
          errors++;
          $display("FAIL b2b_second_setup: got %h want %h",
                   {psel_a, penable_a, pwrite_a, paddr_a}, {3'b100, 8'h41});
        end
        cmd_valid_a = 1'b0;
      end
      if (rsp_valid_a === 1'b1) begin
        seen++;
        checks++;
        if (n != ((seen == 1) ? 3 : 6)) begin
          errors++; $display("FAIL b2b_latency: got %0d want %0d", n, (seen == 1) ? 3 : 6);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err_a, rsp_rdata_a} !== e) begin
            errors++; $display("FAIL b2b_rsp: got %h want %h", {rsp_err_a, rsp_rdata_a}, e);
          end
        end
      end
    end
    cmd_valid_a = 1'b0;
    if (seen < 2) begin
      checks++; errors++; exp_q.delete();
      $display("FAIL b2b_wait: got %0d responses want 2", seen);
    end
  endtask

  task automatic test_reset_mid_access();
    int   n;
    bit   got;
    rsp_t e;
    PREADY = 1'b0; cmd_write = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'h66;
    cmd_valid_a = 1'b1;
    @(posedge PCLK); #1 cmd_valid_a = 1'b0;
    repeat (2) @(negedge PCLK);
    checks++;
    if (penable_a !== 1'b1) begin
      errors++; $display("FAIL rst_pre_access: got %b want 1", penable_a);
    end
    #1 PRESETn = 1'b0;
    #1;
    checks++;
    if ({psel_a, penable_a, cmd_ready_a, paddr_a} !== {3'b001, 8'h00}) begin
      errors++;
      $display("FAIL rst_async_drop: got %h want %h", {psel_a, penable_a, cmd_ready_a, paddr_a},
               {3'b001, 8'h00});
    end
    repeat (2) begin
      @(negedge PCLK);
      checks++;
      if (rsp_valid_a !== 1'b0) begin
        errors++; $display("FAIL rst_no_rsp_during: got %b want 0", rsp_valid_a);
      end
    end
    @(posedge PCLK); #1 PRESETn = 1'b1;
    repeat (6) begin
      @(negedge PCLK);
      checks++;
      if ({rsp_valid_a, cmd_ready_a} !== 2'b01) begin
        errors++; $display("FAIL rst_no_rsp_after: got %b want 01", {rsp_valid_a, cmd_ready_a});
      end
    end
    PREADY = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h01; cmd_wdata = 8'h5E;
    cmd_valid_a = 1'b1;
    exp_q.push_back('{err: 1'b0, rdata: 8'h00});
    @(posedge PCLK); #1 cmd_valid_a = 1'b0;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge PCLK); n++;
      if (n == 2) begin
        checks++;
        if ({penable_a, pwrite_a, paddr_a, pwdata_a} !== {2'b11, 8'h01, 8'h5E}) begin
          errors++;
          $display("FAIL rst_write_access: got %h want %h", {penable_a, pwrite_a, paddr_a, pwdata_a},
                   {2'b11, 8'h01, 8'h5E});
        end
      end
      if (rsp_valid_a === 1'b1) begin
        got = 1'b1;
        checks++;
        if (n != 3) begin
          errors++; $display("FAIL rst_write_latency: got %0d want 3", n);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rst_write_rsp: got unexpected response want none");
        end else begin
          e = exp_q.pop_front();
          if ({rsp_err_a, rsp_rdata_a} !== e) begin
            errors++; $display("FAIL rst_write_rsp: got %h want %h", {rsp_err_a, rsp_rdata_a}, e);
          end
        end
      end
    end
    if (!got) begin
      checks++; errors++; exp_q.delete();
      $display("FAIL rst_write_wait: got no rsp_valid want one within 20 cycles");
    end
  endtask

  // Instance b (TIMEOUT=2): plain abort, then PREADY arriving on the expiry edge.
  task automatic test_timeout_race();
    int   n;
    bit   got;
    rsp_t e;
    for (int pass = 0; pass < 2; pass++) begin
      PREADY = 1'b0; PRDATA = 8'h44; cmd_write = 1'b0; cmd_addr = 8'h70 + 8'(pass);
      cmd_valid_b = 1'b1;
      if (pass == 0) exp_q.push_back('{err: 1'b1, rdata: 8'h00});
      else           exp_q.push_back('{err: 1'b0, rdata: 8'hD2});
      @(posedge PCLK); #1 cmd_valid_b = 1'b0;
      n = 0; got = 1'b0;
      while (!got && n < 20) begin
        @(negedge PCLK); n++;
        if (pass == 1 && n == 3) begin
          PREADY = 1'b1; PRDATA = 8'hD2;
        end
        if (rsp_valid_b === 1'b1) begin
          got = 1'b1;
          checks++;
          if (n != 4) begin
            errors++; $display("FAIL race%0d_latency: got %0d want 4", pass, n);
          end
          checks++;
          if (exp_q.size() == 0) begin
            errors++; $display("FAIL race%0d_rsp: got unexpected response want none", pass);
          end else begin
            e = exp_q.pop_front();
            if ({rsp_err_b, rsp_rdata_b} !== e) begin
              errors++;
              $display("FAIL race%0d_rsp: got %h want %h", pass, {rsp_err_b, rsp_rdata_b}, e);
            end
          end
        end
      end
      if (!got) begin
        checks++; errors++; exp_q.delete();
        $display("FAIL race%0d_wait: got no rsp_valid want one within 20 cycles", pass);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    test_timeout_race();
    repeat (2) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
